// File: rtl/deframer_pkg.sv
// Shared definitions for the receive-side bitstream deframer.
// Holds the receiver state encoding, the frame geometry constants shared with
// the TX bitstream generator, and a small saturating-counter helper.
package deframer_pkg;

    // Receiver states: hunt for preamble, wait for SFD, capture, tail check, deliver.
    typedef enum logic [2:0] {
        HUNT     = 3'd0,
        PRE_LOCK = 3'd1,
        PAYLOAD  = 3'd2,
        TAIL     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int          DEF_FRAME_BITS   = 1200;
    localparam int          DEF_TAIL_BITS    = 10;
    localparam logic [15:0] DEF_SFD_PATTERN  = 16'hFCF3;
    localparam int          DEF_MIN_PREAMBLE = 32;
    localparam int          DEF_SFD_WINDOW   = 64;
    localparam int          DEF_GAP_CYCLES   = 10000;

    // Increment an 8-bit counter, holding at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bitstream_deframer_sfd_correlator.sv
// sfd_correlator: bit-serial start-of-frame-delimiter detector.
// Keeps the last 15 received bits; together with the bit arriving now they form
// the 16-bit window compared against PATTERN (oldest bit in the MSB).
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   clear         - synchronous clear of the history (has priority over shift)
//   shift_en      - shift bit_in into the history this cycle
//   bit_in        - incoming serial bit
//   match         - window {history, bit_in} equals PATTERN (combinational)
//   last_bit      - most recently stored bit, for transition detection
module sfd_correlator
    import deframer_pkg::*;
#(
    parameter logic [15:0] PATTERN = DEF_SFD_PATTERN
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic shift_en,
    input  logic bit_in,
    output logic match,
    output logic last_bit
);

    // The 16th window bit is bit_in itself, so only 15 bits need storage.
    logic [14:0] sr_r;

    // Bit history shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sr_r <= 15'd0;
        end else if (clear) begin
            sr_r <= 15'd0;
        end else if (shift_en) begin
            sr_r <= {sr_r[13:0], bit_in};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign match    = ({sr_r, bit_in} == PATTERN);
    assign last_bit = sr_r[0];

endmodule

// File: rtl/bitstream_deframer.sv
// bitstream_deframer: receive-side framer for the demodulated serial stream.
// Locks on an alternating preamble, aligns on the SFD, captures FRAME_BITS
// payload bits into a shadow register, checks the zero tail and publishes the
// frame with a one-cycle frame_valid pulse.
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   rx_bit         - recovered bit, used only when rx_bit_valid is high
//   rx_bit_valid   - one-cycle strobe per received bit
//   frame_data     - last delivered codeword, k-th payload bit at index k
//   frame_valid    - one-cycle pulse when frame_data/err_tail/frame_count update
//   sync_lock      - high while payload and tail are being received
//   err_tail       - a 1 was seen in the tail of the delivered frame
//   err_abort      - one-cycle pulse on gap timeout or SFD window expiry
//   frame_count    - number of delivered frames, wrapping
module bitstream_deframer
    import deframer_pkg::*;
#(
    parameter int          FRAME_BITS   = DEF_FRAME_BITS,
    parameter int          TAIL_BITS    = DEF_TAIL_BITS,
    parameter logic [15:0] SFD_PATTERN  = DEF_SFD_PATTERN,
    parameter int          MIN_PREAMBLE = DEF_MIN_PREAMBLE,
    parameter int          SFD_WINDOW   = DEF_SFD_WINDOW,
    parameter int          GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_bit,
    input  logic                  rx_bit_valid,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  sync_lock,
    output logic                  err_tail,
    output logic                  err_abort,
    output logic [15:0]           frame_count
);

    localparam logic [7:0]  ALT_LOCK  = 8'(MIN_PREAMBLE - 1);
    localparam logic [7:0]  WIN_LAST  = 8'(SFD_WINDOW - 1);
    localparam logic [10:0] PAY_LAST  = 11'(FRAME_BITS - 1);
    localparam logic [10:0] TAIL_LAST = 11'(TAIL_BITS - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t                state_r;
    state_t                state_s;
    logic [7:0]            alt_cnt_r;
    logic [7:0]            win_cnt_r;
    logic [10:0]           bit_cnt_r;
    logic [15:0]           gap_cnt_r;
    logic                  tail_flag_r;
    logic [FRAME_BITS-1:0] frame_shadow_r;
    logic [FRAME_BITS-1:0] frame_data_r;
    logic                  frame_valid_r;
    logic                  sync_lock_r;
    logic                  err_tail_r;
    logic                  err_abort_r;
    logic [15:0]           frame_count_r;

    logic       match_s;
    logic       last_bit_s;
    logic [7:0] alt_next_s;
    logic       gap_hit_s;
    logic       abort_s;
    logic       done_entry_s;

    sfd_correlator #(
        .PATTERN (SFD_PATTERN)
    ) u_sfd (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (state_r == DONE),
        .shift_en (rx_bit_valid),
        .bit_in   (rx_bit),
        .match    (match_s),
        .last_bit (last_bit_s)
    );

    // A transition against the previous bit extends the alternating run.
    assign alt_next_s   = (rx_bit != last_bit_s) ? sat_inc8(alt_cnt_r) : 8'd0;
    assign gap_hit_s    = !rx_bit_valid && (gap_cnt_r == GAP_LAST);
    assign done_entry_s = (state_r == TAIL) && (state_s == DONE);

    // Next-state logic and abort detection.
    always_comb begin
        state_s = state_r;
        abort_s = 1'b0;
        case (state_r)
            HUNT: begin
                if (rx_bit_valid && (alt_next_s >= ALT_LOCK)) begin
                    state_s = PRE_LOCK;
                end else begin
                    state_s = HUNT;
                end
            end
            PRE_LOCK: begin
                if (rx_bit_valid) begin
                    if (match_s) begin
                        state_s = PAYLOAD;
                    end else if (win_cnt_r == WIN_LAST) begin
                        state_s = HUNT;
                        abort_s = 1'b1;
                    end else begin
                        state_s = PRE_LOCK;
                    end
                end else if (gap_hit_s) begin
                    state_s = HUNT;
                    abort_s = 1'b1;
                end else begin
                    state_s = PRE_LOCK;
                end
            end
            PAYLOAD: begin
                if (rx_bit_valid) begin
                    if (bit_cnt_r == PAY_LAST) begin
                        state_s = TAIL;
                    end else begin
                        state_s = PAYLOAD;
                    end
                end else if (gap_hit_s) begin
                    state_s = HUNT;
                    abort_s = 1'b1;
                end else begin
                    state_s = PAYLOAD;
                end
            end
            TAIL: begin
                if (rx_bit_valid) begin
                    if (bit_cnt_r == TAIL_LAST) begin
                        state_s = DONE;
                    end else begin
                        state_s = TAIL;
                    end
                end else if (gap_hit_s) begin
                    state_s = HUNT;
                    abort_s = 1'b1;
                end else begin
                    state_s = TAIL;
                end
            end
            DONE: begin
                state_s = HUNT;
            end
            default: begin
                state_s = HUNT;
            end
        endcase
    end

    // State register and bit/gap/preamble counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= HUNT;
            alt_cnt_r   <= 8'd0;
            win_cnt_r   <= 8'd0;
            bit_cnt_r   <= 11'd0;
            gap_cnt_r   <= 16'd0;
            tail_flag_r <= 1'b0;
        end else begin
            state_r <= state_s;

            // Saturate so a long silence keeps the timeout condition asserted.
            if (rx_bit_valid) begin
                gap_cnt_r <= 16'd0;
            end else if (gap_cnt_r == GAP_LAST) begin
                gap_cnt_r <= gap_cnt_r;
            end else begin
                gap_cnt_r <= gap_cnt_r + 16'd1;
            end

            // Leaving HUNT always restarts the preamble search from scratch.
            if (state_r == HUNT) begin
                if (rx_bit_valid) begin
                    alt_cnt_r <= alt_next_s;
                end else if (gap_hit_s) begin
                    alt_cnt_r <= 8'd0;
                end else begin
                    alt_cnt_r <= alt_cnt_r;
                end
            end else begin
                alt_cnt_r <= 8'd0;
            end

            if (state_r == PRE_LOCK) begin
                win_cnt_r <= rx_bit_valid ? (win_cnt_r + 8'd1) : win_cnt_r;
            end else begin
                win_cnt_r <= 8'd0;
            end

            // bit_cnt restarts at each PAYLOAD->TAIL boundary.
            if ((state_r == PAYLOAD) || (state_r == TAIL)) begin
                if (rx_bit_valid) begin
                    bit_cnt_r <= (state_s != state_r) ? 11'd0 : (bit_cnt_r + 11'd1);
                end else begin
                    bit_cnt_r <= bit_cnt_r;
                end
            end else begin
                bit_cnt_r <= 11'd0;
            end

            if (state_r == TAIL) begin
                tail_flag_r <= tail_flag_r | (rx_bit_valid & rx_bit);
            end else begin
                tail_flag_r <= 1'b0;
            end
        end
    end

    // Payload capture into the shadow so frame_data keeps the previous frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_shadow_r <= '0;
        end else if ((state_r == PAYLOAD) && rx_bit_valid) begin
            frame_shadow_r[bit_cnt_r] <= rx_bit;
        end else begin
            frame_shadow_r <= frame_shadow_r;
        end
    end

    // Output registers; delivery happens on the edge that enters DONE so that
    // frame_valid is visible one clock after the last tail strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_data_r  <= '0;
            frame_valid_r <= 1'b0;
            sync_lock_r   <= 1'b0;
            err_tail_r    <= 1'b0;
            err_abort_r   <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            frame_valid_r <= done_entry_s;
            err_abort_r   <= abort_s;
            sync_lock_r   <= (state_s == PAYLOAD) || (state_s == TAIL);
            if (done_entry_s) begin
                frame_data_r  <= frame_shadow_r;
                err_tail_r    <= tail_flag_r | rx_bit;
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_data_r  <= frame_data_r;
                err_tail_r    <= err_tail_r;
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign frame_data  = frame_data_r;
    assign frame_valid = frame_valid_r;
    assign sync_lock   = sync_lock_r;
    assign err_tail    = err_tail_r;
    assign err_abort   = err_abort_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_bitstream_deframer.sv
// Self-checking bench for bitstream_deframer. Stimulus tasks push the expected
// frame into a scoreboard queue; a negedge monitor pops and compares whenever
// frame_valid is seen and counts err_abort pulses for the abort scenarios.
module tb_bitstream_deframer;

    localparam int FB = 1200;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rx_bit = 1'b0;
    logic          rx_bit_valid = 1'b0;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          sync_lock;
    logic          err_tail;
    logic          err_abort;
    logic [15:0]   frame_count;

    always #5 clk = ~clk;

    bitstream_deframer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_bit       (rx_bit),
        .rx_bit_valid (rx_bit_valid),
        .frame_data   (frame_data),
        .frame_valid  (frame_valid),
        .sync_lock    (sync_lock),
        .err_tail     (err_tail),
        .err_abort    (err_abort),
        .frame_count  (frame_count)
    );

    typedef struct {
        logic [FB-1:0] data;
        logic          err;
        logic [15:0]   count;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            errors = 0;
    int            abort_cnt = 0;
    int            fv_cnt = 0;
    int            a0;
    int            f0;
    logic [15:0]   exp_count = 16'd0;
    logic [FB-1:0] seq_a;
    logic [FB-1:0] seq_b;
    logic [FB-1:0] seq_c;
    logic [FB-1:0] last_data = '0;
    logic [FB-1:0] zero_data = '0;
    logic [63:0]   junk = 64'h0F0F_0F0F_33CC_33CC;

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [FB-1:0] got, input logic [FB-1:0] exp);
        int first;
        checks++;
        if (got !== exp) begin
            errors++;
            first = -1;
            for (int i = FB - 1; i >= 0; i--) begin
                if (got[i] !== exp[i]) first = i;
            end
            $display("FAIL %s: first differing bit %0d got %b expected %b",
                     name, first, got[first], exp[first]);
        end
    endtask

    // Fibonacci LFSR x^16+x^14+x^13+x^11; element k is the k-th transmitted bit.
    function automatic logic [FB-1:0] gen_seq(input logic [15:0] seed);
        logic [FB-1:0] s;
        logic [15:0]   l;
        l = seed;
        for (int k = 0; k < FB; k++) begin
            s[k] = l[15];
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        return s;
    endfunction

    task automatic send_bit(input logic b);
        rx_bit       = b;
        rx_bit_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_bit_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_preamble(input int n);
        for (int i = 0; i < n; i++) send_bit((i % 2) == 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_frame(input int pre, input logic [FB-1:0] seq, input int errpos);
        exp_t e;
        exp_count = exp_count + 16'd1;
        e.data  = seq;
        e.err   = (errpos >= 0);
        e.count = exp_count;
        sb_q.push_back(e);
        send_preamble(pre);
        send_byte(8'hFC);
        send_byte(8'hF3);
        for (int k = 0; k < FB; k++) send_bit(seq[k]);
        check1("sync_lock_in_tail", {31'd0, sync_lock}, 32'd1);
        for (int k = 0; k < 10; k++) send_bit(k == errpos);
        repeat (3) @(posedge clk);
        #1;
        check1("sync_lock_after_frame", {31'd0, sync_lock}, 32'd0);
        last_data = seq;
    endtask

    // Scoreboard monitor: compare each delivered frame, count abort pulses.
    always @(negedge clk) begin
        if (reset_n) begin
            if (err_abort) abort_cnt++;
            if (frame_valid) begin
                fv_cnt++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_valid: got frame_count %0d expected no frame", frame_count);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_data("frame_data", frame_data, mon_e.data);
                    check1("err_tail", {31'd0, err_tail}, {31'd0, mon_e.err});
                    check1("frame_count", {16'd0, frame_count}, {16'd0, mon_e.count});
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        seq_a = gen_seq(16'hACE1);
        seq_b = gen_seq(16'h1D35);
        seq_c = gen_seq(16'h7A0F);
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_data("reset_frame_data", frame_data, zero_data);
        check1("reset_frame_valid", {31'd0, frame_valid}, 32'd0);
        check1("reset_sync_lock", {31'd0, sync_lock}, 32'd0);
        check1("reset_err_tail", {31'd0, err_tail}, 32'd0);
        check1("reset_err_abort", {31'd0, err_abort}, 32'd0);
        check1("reset_frame_count", {16'd0, frame_count}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Long preamble, clean frame; then same payload with tail bit 5 set;
        // then a different clean frame to show err_tail is per frame.
        send_frame(512, seq_a, -1);
        send_frame(40, seq_a, 5);
        send_frame(40, seq_b, -1);

        // Preamble lock but no SFD inside the window.
        a0 = abort_cnt;
        send_preamble(40);
        for (int k = 63; k >= 0; k--) send_bit(junk[k]);
        repeat (3) @(posedge clk);
        #1;
        check1("sfd_window_abort", a0 - abort_cnt + 2 * (abort_cnt - a0), 32'd1);
        check1("sfd_window_count", {16'd0, frame_count}, {16'd0, exp_count});
        check1("sfd_window_lock", {31'd0, sync_lock}, 32'd0);

        // Stall after payload bit 300.
        a0 = abort_cnt;
        send_preamble(40);
        send_byte(8'hFC);
        send_byte(8'hF3);
        for (int k = 0; k <= 300; k++) send_bit(seq_c[k]);
        check1("gap_lock_before", {31'd0, sync_lock}, 32'd1);
        repeat (9900) @(posedge clk);
        #1;
        check1("gap_not_early", abort_cnt - a0, 32'd0);
        repeat (200) @(posedge clk);
        #1;
        check1("gap_abort", abort_cnt - a0, 32'd1);
        check_data("gap_data_held", frame_data, last_data);
        check1("gap_count_held", {16'd0, frame_count}, {16'd0, exp_count});
        check1("gap_lock_after", {31'd0, sync_lock}, 32'd0);

        // Preamble too short: nothing may be delivered.
        f0 = fv_cnt;
        send_preamble(20);
        send_byte(8'hFC);
        send_byte(8'hF3);
        for (int k = 0; k < FB; k++) send_bit(seq_a[k]);
        for (int k = 0; k < 10; k++) send_bit(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check1("short_pre_no_frame", fv_cnt - f0, 32'd0);
        check1("short_pre_count", {16'd0, frame_count}, {16'd0, exp_count});

        // Fresh reset, two frames, reset in the middle of a third.
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_count = 16'd0;
        @(posedge clk);
        #1;
        send_frame(40, seq_a, -1);
        send_frame(40, seq_b, -1);
        check1("b2b_count", {16'd0, frame_count}, 32'd2);
        send_preamble(40);
        send_byte(8'hFC);
        send_byte(8'hF3);
        for (int k = 0; k < 600; k++) send_bit(seq_c[k]);
        check1("mid_lock", {31'd0, sync_lock}, 32'd1);
        reset_n = 1'b0;
        #2;
        check1("mid_reset_count", {16'd0, frame_count}, 32'd0);
        check_data("mid_reset_data", frame_data, zero_data);
        check1("mid_reset_lock", {31'd0, sync_lock}, 32'd0);
        check1("mid_reset_valid", {31'd0, frame_valid}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_count = 16'd0;
        send_frame(40, seq_c, -1);

        repeat (5) @(posedge clk);
        #1;
        check1("scoreboard_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
